domain_sequencer: RTL and testbench

- Multi-cycle instruction sequencer: the initiator side of the CPU execution domain.
- Accepts 24-bit instructions over a valid/ready handshake.
- Reads source registers from the register bank, drives the ALU, and writes results back through the bank write port.
- Sits above the domain datapath. Provides the regsel/reg_val/reg_we traffic and ALU operand/opcode drive that the datapath consumes.

---
 rtl/domain_sequencer.sv | 150 +++++++++++++++
 tb/tb_domain_sequencer.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/domain_sequencer.sv
// ============================================================================
//  Module   : domain_sequencer
//  Purpose  : Multi-cycle instruction sequencer that reads operands from the
//             register bank, drives the ALU and writes results back.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module domain_sequencer #(
   parameter int REG_W = 8,
   parameter int SEL_W = 6,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [23:0]      instr,
   input  logic             instr_valid,
   output logic             instr_ready,
   output logic [SEL_W-1:0] rf_sel,
   input  logic [REG_W-1:0] rf_rdata,
   output logic             rf_we,
   output logic [REG_W-1:0] rf_wdata,
   output logic [2:0]       alu_op,
   output logic [REG_W-1:0] alu_a,
   output logic [REG_W-1:0] alu_b,
   input  logic [REG_W-1:0] alu_result,
   output logic             busy,
   output logic             err,
   output logic [CNT_W-1:0] retired
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RD_A = 3'd1,
      RD_B = 3'd2,
      EXEC = 3'd3,
      WB   = 3'd4
   } state_t;

   localparam logic [3:0] c_op_ldi = 4'h8;
   localparam logic [3:0] c_op_mov = 4'h9;
   localparam logic [3:0] c_op_nop = 4'hF;

   state_t           r_state;
   logic [3:0]       r_op;
   logic [5:0]       r_rd;
   logic [5:0]       r_rs;
   logic [7:0]       r_imm;
   logic [REG_W-1:0] r_a;
   logic [REG_W-1:0] r_b;
   logic             r_err;
   logic [CNT_W-1:0] r_retired;

   logic [3:0]       w_op;
   logic [5:0]       w_rd;
   logic [5:0]       w_rs;

   assign w_op = instr[23:20];
   assign w_rd = instr[19:14];
   assign w_rs = instr[13:8];

   assign instr_ready = (r_state == IDLE) && !reset;
   assign busy        = (r_state != IDLE);
   assign err         = r_err;
   assign retired     = r_retired;
   assign alu_op      = r_op[2:0];
   assign alu_a       = r_a;
   assign alu_b       = r_b;

   // ALU results pass straight through in WB so the write sees this cycle's operands.
   always_comb begin
      rf_wdata = '0;
      if (r_state == WB) begin
         if (r_op == c_op_ldi)
            rf_wdata = REG_W'(r_imm);
         else if (r_op == c_op_mov)
            rf_wdata = r_b;
         else
            rf_wdata = alu_result;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= IDLE;
         r_op      <= '0;
         r_rd      <= '0;
         r_rs      <= '0;
         r_imm     <= '0;
         r_a       <= '0;
         r_b       <= '0;
         r_err     <= 1'b0;
         r_retired <= '0;
         rf_sel    <= '0;
         rf_we     <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (instr_valid) begin
                  r_op  <= w_op;
                  r_rd  <= w_rd;
                  r_rs  <= w_rs;
                  r_imm <= instr[7:0];
                  if (!w_op[3]) begin
                     r_state <= RD_A;
                     rf_sel  <= SEL_W'(w_rd);
                  end else if (w_op == c_op_mov) begin
                     r_state <= RD_B;
                     rf_sel  <= SEL_W'(w_rs);
                  end else if (w_op == c_op_ldi) begin
                     r_state <= WB;
                     rf_sel  <= SEL_W'(w_rd);
                     rf_we   <= 1'b1;
                  end else if (w_op == c_op_nop) begin
                     r_retired <= r_retired + CNT_W'(1);
                  end else begin
                     r_err <= 1'b1;
                  end
               end
            end
            RD_A: begin
               rf_sel  <= SEL_W'(r_rs);
               r_state <= RD_B;
            end
            RD_B: begin
               r_a     <= rf_rdata;
               r_state <= EXEC;
            end
            EXEC: begin
               r_b     <= rf_rdata;
               rf_sel  <= SEL_W'(r_rd);
               rf_we   <= 1'b1;
               r_state <= WB;
            end
            WB: begin
               rf_we     <= 1'b0;
               r_retired <= r_retired + CNT_W'(1);
               r_state   <= IDLE;
            end
            default: begin
               rf_we   <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_domain_sequencer.sv
// ============================================================================
//  Module   : tb_domain_sequencer
//  Purpose  : Scoreboard bench for domain_sequencer with bank and ALU models.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_domain_sequencer;

   logic        clk;
   logic        reset;
   logic [23:0] instr;
   logic        instr_valid;
   logic        instr_ready;
   logic [5:0]  rf_sel;
   logic [7:0]  rf_rdata;
   logic        rf_we;
   logic [7:0]  rf_wdata;
   logic [2:0]  alu_op;
   logic [7:0]  alu_a;
   logic [7:0]  alu_b;
   logic [7:0]  alu_result;
   logic        busy;
   logic        err;
   logic [15:0] retired;

   domain_sequencer #(.REG_W(8), .SEL_W(6), .CNT_W(16)) dut (
      .clk        (clk),
      .reset      (reset),
      .instr      (instr),
      .instr_valid(instr_valid),
      .instr_ready(instr_ready),
      .rf_sel     (rf_sel),
      .rf_rdata   (rf_rdata),
      .rf_we      (rf_we),
      .rf_wdata   (rf_wdata),
      .alu_op     (alu_op),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_result (alu_result),
      .busy       (busy),
      .err        (err),
      .retired    (retired)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cycle = 0;
   always @(posedge clk) cycle <= cycle + 1;

   // Register bank model: registered read, write on rf_we.
   logic       preload;
   logic [7:0] bank [64];
   always @(posedge clk) begin
      if (preload) begin
         bank[1] <= 8'hA5;
         bank[2] <= 8'h10;
         bank[3] <= 8'h05;
      end else if (rf_we) begin
         bank[rf_sel] <= rf_wdata;
      end
      rf_rdata <= bank[rf_sel];
   end

   always_comb begin
      case (alu_op)
         3'd0:    alu_result = alu_a + alu_b;
         3'd1:    alu_result = alu_a | alu_b;
         3'd2:    alu_result = alu_a & alu_b;
         3'd3:    alu_result = alu_a ^ alu_b;
         3'd4:    alu_result = alu_a - alu_b;
         3'd5:    alu_result = alu_a;
         3'd6:    alu_result = alu_b;
         default: alu_result = ~alu_a;
      endcase
   end

   typedef struct {
      int         cyc;
      bit         wr;
      logic [5:0] sel;
      logic [7:0] data;
      bit         chk_ab;
      logic [7:0] a;
      logic [7:0] b;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
      end
   endtask

   task automatic push(input int cyc, input bit wr, input logic [5:0] sel,
                       input logic [7:0] data, input bit chk_ab,
                       input logic [7:0] a, input logic [7:0] b);
      exp_t e;
      e.cyc = cyc; e.wr = wr; e.sel = sel; e.data = data;
      e.chk_ab = chk_ab; e.a = a; e.b = b;
      q.push_back(e);
   endtask

   // Monitor: compares the DUT each cycle against the scheduled expectations.
   always @(negedge clk) begin
      while (q.size() > 0 && q[0].cyc < cycle) begin
         checks++;
         errors++;
         $display("FAIL missed_event: expected at cycle %0d, now %0d", q[0].cyc, cycle);
         void'(q.pop_front());
      end
      if (q.size() > 0 && q[0].cyc == cycle) begin
         mon_e = q.pop_front();
         chk("rf_we", rf_we, mon_e.wr);
         chk("rf_sel", rf_sel, mon_e.sel);
         if (mon_e.wr) chk("rf_wdata", rf_wdata, mon_e.data);
         if (mon_e.chk_ab) begin
            chk("alu_a", alu_a, mon_e.a);
            chk("alu_b", alu_b, mon_e.b);
         end
      end else if (rf_we) begin
         checks++;
         errors++;
         $display("FAIL unexpected_write: rf_we=1 sel=%0h wdata=%0h, required rf_we=0", rf_sel, rf_wdata);
      end
   end

   // Called at a negedge; returns after the accepting edge with acc = first post-accept cycle.
   task automatic send(input logic [23:0] w, input bit hold, output int acc);
      int n;
      instr       = w;
      instr_valid = 1'b1;
      n = 0;
      while (!instr_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!instr_ready) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: instr_ready=0, required 1 within 20 cycles");
         instr_valid = 1'b0;
         acc = -100;
      end else begin
         acc = cycle + 1;
         @(posedge clk);
         #1;
         if (!hold) instr_valid = 1'b0;
      end
   endtask

   task automatic idle_wait();
      int n;
      n = 0;
      @(negedge clk);
      while (busy && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (busy) begin
         checks++;
         errors++;
         $display("FAIL idle_timeout: busy=1, required 0 within 20 cycles");
      end
   endtask

   initial begin
      int acc, acc2, n;
      reset       = 1'b1;
      preload     = 1'b1;
      instr       = '0;
      instr_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_instr_ready", instr_ready, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_rf_we", rf_we, 1'b0);
      chk("rst_rf_sel", rf_sel, 6'd0);
      chk("rst_retired", retired, 16'd0);
      chk("rst_err", err, 1'b0);
      chk("rst_alu_a", alu_a, 8'd0);
      chk("rst_alu_op", alu_op, 3'd0);
      preload = 1'b0;
      reset   = 1'b0;
      #1 chk("ready_after_reset", instr_ready, 1'b1);

      // LDI r5 <= 0x3C
      @(negedge clk);
      send({4'h8, 6'd5, 6'd0, 8'h3C}, 1'b0, acc);
      push(acc, 1'b1, 6'd5, 8'h3C, 1'b0, 8'h0, 8'h0);
      @(negedge clk);
      chk("ldi_wb_busy", busy, 1'b1);
      chk("ldi_wb_ready", instr_ready, 1'b0);
      @(negedge clk);
      chk("ldi_ready_after_wb", instr_ready, 1'b1);
      chk("ldi_retired", retired, 16'd1);

      // ALU op1 (OR): r2 <= r2 | r3 = 0x10 | 0x05
      @(negedge clk);
      send({4'h1, 6'd2, 6'd3, 8'h00}, 1'b0, acc);
      push(acc,     1'b0, 6'd2, 8'h00, 1'b0, 8'h0,  8'h0);
      push(acc + 1, 1'b0, 6'd3, 8'h00, 1'b0, 8'h0,  8'h0);
      push(acc + 2, 1'b0, 6'd3, 8'h00, 1'b0, 8'h0,  8'h0);
      push(acc + 3, 1'b1, 6'd2, 8'h15, 1'b1, 8'h10, 8'h05);
      idle_wait();
      chk("alu_retired", retired, 16'd2);

      // Back-to-back MOVs with valid held: r7 <= r1, then r4 <= r7
      @(negedge clk);
      send({4'h9, 6'd7, 6'd1, 8'h00}, 1'b1, acc);
      push(acc,     1'b0, 6'd1, 8'h00, 1'b0, 8'h0, 8'h0);
      push(acc + 1, 1'b0, 6'd1, 8'h00, 1'b0, 8'h0, 8'h0);
      push(acc + 2, 1'b1, 6'd7, 8'hA5, 1'b0, 8'h0, 8'h0);
      send({4'h9, 6'd4, 6'd7, 8'h00}, 1'b0, acc2);
      chk("mov_b2b_accept_cycle", acc2, acc + 4);
      push(acc2,     1'b0, 6'd7, 8'h00, 1'b0, 8'h0, 8'h0);
      push(acc2 + 1, 1'b0, 6'd7, 8'h00, 1'b0, 8'h0, 8'h0);
      push(acc2 + 2, 1'b1, 6'd4, 8'hA5, 1'b0, 8'h0, 8'h0);
      idle_wait();
      chk("mov_retired", retired, 16'd4);

      // Illegal op 0xC, then LDI still executes
      @(negedge clk);
      send({4'hC, 6'd1, 6'd2, 8'h33}, 1'b0, acc);
      @(negedge clk);
      chk("illegal_err", err, 1'b1);
      chk("illegal_ready", instr_ready, 1'b1);
      chk("illegal_busy", busy, 1'b0);
      chk("illegal_retired", retired, 16'd4);
      send({4'h8, 6'd9, 6'd0, 8'h77}, 1'b0, acc);
      push(acc, 1'b1, 6'd9, 8'h77, 1'b0, 8'h0, 8'h0);
      @(negedge clk);
      @(negedge clk);
      chk("err_sticky", err, 1'b1);
      chk("post_illegal_retired", retired, 16'd5);

      // ALU op abandoned by reset during EXEC
      @(negedge clk);
      send({4'h0, 6'd2, 6'd3, 8'h00}, 1'b0, acc);
      push(acc,     1'b0, 6'd2, 8'h00, 1'b0, 8'h0, 8'h0);
      push(acc + 1, 1'b0, 6'd3, 8'h00, 1'b0, 8'h0, 8'h0);
      repeat (3) @(negedge clk);
      chk("exec_busy_before_reset", busy, 1'b1);
      #2 reset = 1'b1;
      #1;
      chk("midrst_rf_we", rf_we, 1'b0);
      chk("midrst_busy", busy, 1'b0);
      chk("midrst_ready", instr_ready, 1'b0);
      chk("midrst_retired", retired, 16'd0);
      chk("midrst_err", err, 1'b0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      #1 chk("ready_after_midrst", instr_ready, 1'b1);
      @(negedge clk);
      chk("retired_after_midrst", retired, 16'd0);
      chk("busy_after_midrst", busy, 1'b0);

      // 65535 NOPs then LDI: retired wraps to zero on that write-back
      instr       = {4'hF, 20'h00000};
      instr_valid = 1'b1;
      repeat (65535) @(posedge clk);
      #1 instr_valid = 1'b0;
      @(negedge clk);
      chk("nop_preload_retired", retired, 16'hFFFF);
      chk("nop_no_busy", busy, 1'b0);
      send({4'h8, 6'd10, 6'd0, 8'h5A}, 1'b0, acc);
      push(acc, 1'b1, 6'd10, 8'h5A, 1'b0, 8'h0, 8'h0);
      @(negedge clk);
      chk("wrap_pre_retired", retired, 16'hFFFF);
      @(negedge clk);
      chk("wrap_retired", retired, 16'h0000);

      n = 0;
      while (q.size() > 0 && n < 10) begin
         @(negedge clk);
         n++;
      end
      if (q.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d expectations outstanding, required 0", q.size());
      end
      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
